// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: single-port on-chip data memory with a valid/ready request
// channel and a valid/ready response channel.
//
// Every accepted request (read or write) yields exactly one response, in
// accept order. A request moves through a READ_LAT-deep pipeline and then
// into a MAX_OUT-deep response FIFO. The head of that FIFO drives the
// response port.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_we, req_addr            write/read select and word address
//   req_wdata, req_be           write data and byte-lane enables
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata                   read data (0 for writes and errors)
//   rsp_is_write, rsp_err       response kind and out-of-range flag
module mem_port_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1,
  parameter int MAX_OUT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_is_write,
  output logic                rsp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef struct packed {
    logic              we;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;
  rsp_t                pipe_q [READ_LAT];
  rsp_t                pipe_d [READ_LAT];

  rsp_t             fifo_q [MAX_OUT];
  rsp_t             fifo_d [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [OUT_W-1:0] out_q, out_d;

  logic              accept, in_range, wr_en, push, pop;
  logic [IDX_W-1:0]  addr_idx;
  logic [DATA_W-1:0] rd_data;
  rsp_t              head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // The outstanding limit bounds both pipeline and FIFO occupancy, so
  // req_ready is the only flow control needed on the request side.
  assign req_ready = (out_q < OUT_W'(MAX_OUT)) && !reset;
  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, req_addr} < DEPTH_L;
  assign addr_idx  = req_addr[IDX_W-1:0];
  assign wr_en     = accept && req_we && in_range;
  // Array read happens before this edge's write lands (only one request per
  // edge, so a read never races its own write).
  assign rd_data   = (in_range && !req_we) ? mem_q[addr_idx] : '0;

  assign push = pipe_vld_q[READ_LAT-1];
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) mem_q[addr_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_vld_d[0] = accept;
    pipe_d[0]     = '{we: req_we, err: !in_range, data: rd_data};
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_d[i]     = pipe_q[i-1];
    end
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    out_d      = out_q;
    if (push) begin
      fifo_d[wr_ptr_q] = pipe_q[READ_LAT-1];
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop) fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
    if (accept && !pop) out_d = out_q + 1'b1;
    else if (!accept && pop) out_d = out_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_q      <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_q      <= out_d;
    end
  end

  // Payload storage needs no reset; the valid bits and count gate it.
  always_ff @(posedge clk) begin
    pipe_q <= pipe_d;
    fifo_q <= fifo_d;
  end

  // The head stays put until popped, so held responses are stable.
  // Outputs are forced to 0 when empty to give clean reset values.
  assign head         = fifo_q[rd_ptr_q];
  assign rsp_valid    = (fifo_cnt_q != '0);
  assign rsp_rdata    = rsp_valid ? head.data : '0;
  assign rsp_is_write = rsp_valid && head.we;
  assign rsp_err      = rsp_valid && head.err;

endmodule

// File: tb/tb_mem_port_ctrl.sv
module tb_mem_port_ctrl;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int DEP = 1024;
  localparam int LAT = 2;
  localparam int MO  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_be = '0;
  logic          rsp_ready = 1'b1;
  logic          req_ready, rsp_valid, rsp_is_write, rsp_err;
  logic [DW-1:0] rsp_rdata;

  mem_port_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .READ_LAT(LAT), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_is_write(rsp_is_write), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a plain memory plus an ordered list of pending responses, each
  // tagged with the cycle it first becomes visible (accept edge + LAT).
  typedef struct {
    int            due;
    logic          we;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mm [DEP];
  logic          m_pop, m_acc;
  exp_t          m_e;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      m_pop = (q.size() > 0) && (q[0].due <= cyc) && rsp_ready;
      m_acc = req_valid && (q.size() < MO);
      if (m_pop) void'(q.pop_front());
      if (m_acc) begin
        m_e.due  = cyc + 1 + LAT;
        m_e.we   = req_we;
        m_e.err  = (int'(req_addr) >= DEP);
        m_e.data = '0;
        if (!m_e.err) begin
          if (req_we) begin
            for (int b = 0; b < 2; b++)
              if (req_be[b]) mm[req_addr[9:0]][8*b +: 8] = req_wdata[8*b +: 8];
          end else begin
            m_e.data = mm[req_addr[9:0]];
          end
        end
        q.push_back(m_e);
      end
    end
    cyc++;
  end

  logic exp_v;
  always @(negedge clk) begin
    exp_v = (q.size() > 0) && (q[0].due <= cyc);
    chk("req_ready", req_ready, (q.size() < MO) && !reset);
    chk("rsp_valid", rsp_valid, exp_v);
    if (exp_v) begin
      chk("rsp_rdata", rsp_rdata, q[0].data);
      chk("rsp_is_write", rsp_is_write, q[0].we);
      chk("rsp_err", rsp_err, q[0].err);
    end
  end

  // Log of consumed responses for the hand-computed checks.
  typedef struct {
    int            c;
    logic [DW-1:0] data;
    logic          we;
    logic          err;
  } log_t;
  log_t lg[$];

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready)
      lg.push_back('{c: cyc, data: rsp_rdata, we: rsp_is_write, err: rsp_err});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [1:0] be, output int acc_cyc, output bit stalled);
    int tries;
    bit r;
    tries = 0;
    stalled = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    do begin
      @(negedge clk);
      r = req_ready;
      tick();
      tries++;
      if (!r) stalled = 1;
    end while (!r && tries < 50);
    if (!r) begin
      total++; bad++;
      $display("FAIL send_timeout: addr %0h not accepted after %0d cycles", a, tries);
    end
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  int a, ra, first, nacc;
  bit s, stall_any, r;

  initial begin
    // Reset for two edges
    tick();
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    tick();

    // Byte-lane writes then read-after-write
    lg.delete();
    send(1'b1, 16'd5, 16'hA5A5, 2'b11, a, s);
    send(1'b1, 16'd5, 16'h3C00, 2'b10, a, s);
    send(1'b0, 16'd5, 16'h0000, 2'b00, ra, s);
    wait_cycles(8);
    chk("t2_nrsp", lg.size(), 3);
    if (lg.size() == 3) begin
      chk("t2_w0_is_write", lg[0].we, 1);
      chk("t2_w0_rdata", lg[0].data, 0);
      chk("t2_w1_is_write", lg[1].we, 1);
      chk("t2_w1_rdata", lg[1].data, 0);
      chk("t2_rd_rdata", lg[2].data, 16'h3CA5);
      chk("t2_rd_latency", lg[2].c, ra + LAT);
    end

    // Preload 0..7 with their address, then 8 back-to-back reads
    for (int i = 0; i < 8; i++) send(1'b1, AW'(i), DW'(i), 2'b11, a, s);
    wait_cycles(8);
    lg.delete();
    stall_any = 0;
    first = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, AW'(i), 16'h0, 2'b00, a, s);
      if (i == 0) first = a;
      stall_any |= s;
    end
    wait_cycles(10);
    chk("t3_no_stall", stall_any, 0);
    chk("t3_nrsp", lg.size(), 8);
    if (lg.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t3_rdata", lg[i].data, i);
        chk("t3_cycle", lg[i].c, first + LAT + i);
      end
    end

    // Backpressure: offer 6 reads with rsp_ready low
    rsp_ready = 1'b0;
    lg.delete();
    nacc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd1; req_be = 2'b00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r = req_ready;
      tick();
      if (r) begin
        nacc++;
        req_addr = req_addr + 16'd1;
      end
    end
    req_valid = 1'b0;
    chk("t4_accepted", nacc, MO);
    @(negedge clk);
    chk("t4_ready_full", req_ready, 0);
    chk("t4_head_valid", rsp_valid, 1);
    chk("t4_head_hold0", rsp_rdata, 16'd1);
    tick();
    @(negedge clk);
    chk("t4_head_hold1", rsp_rdata, 16'd1);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_before_pop", req_ready, 0);
    tick();
    @(negedge clk);
    chk("t4_ready_after_pop", req_ready, 1);
    tick();
    wait_cycles(8);
    chk("t4_nrsp", lg.size(), 4);
    if (lg.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t4_order", lg[i].data, i + 1);
    end

    // Out of range write/read, then addr 0 must be untouched
    lg.delete();
    send(1'b1, 16'd1024, 16'hFFFF, 2'b11, a, s);
    send(1'b0, 16'd1024, 16'h0, 2'b00, a, s);
    send(1'b0, 16'd0, 16'h0, 2'b00, a, s);
    wait_cycles(8);
    chk("t5_nrsp", lg.size(), 3);
    if (lg.size() == 3) begin
      chk("t5_w_err", lg[0].err, 1);
      chk("t5_w_is_write", lg[0].we, 1);
      chk("t5_w_rdata", lg[0].data, 0);
      chk("t5_r_err", lg[1].err, 1);
      chk("t5_r_is_write", lg[1].we, 0);
      chk("t5_r_rdata", lg[1].data, 0);
      chk("t5_addr0_err", lg[2].err, 0);
      chk("t5_addr0_rdata", lg[2].data, 0);
    end

    // Reset with reads in flight
    send(1'b1, 16'd100, 16'hBEEF, 2'b11, a, s);
    wait_cycles(6);
    rsp_ready = 1'b0;
    lg.delete();
    send(1'b0, 16'd1, 16'h0, 2'b00, a, s);
    send(1'b0, 16'd2, 16'h0, 2'b00, a, s);
    send(1'b0, 16'd3, 16'h0, 2'b00, a, s);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    wait_cycles(10);
    chk("t6_no_rsp", lg.size(), 0);
    send(1'b0, 16'd100, 16'h0, 2'b00, a, s);
    wait_cycles(6);
    chk("t6_nrsp_after", lg.size(), 1);
    if (lg.size() == 1) chk("t6_rdata", lg[0].data, 16'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
